// File: rtl/fast_pkt_gen.sv
// FAST-format beat replayer with a fixed inter-packet gap,
// plus a framing monitor on the core's packet output.
module fast_pkt_gen #(
  parameter int MEM_DEPTH   = 1024,
  parameter int ADDR_WIDTH  = 10,
  parameter int START_DELAY = 16,
  parameter int IPG         = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         gen_en_i,
  output logic         data_in_valid,
  output logic [133:0] data_in,
  input  logic         data_out_valid,
  input  logic [133:0] data_out,
  output logic [15:0]  tx_pkt_cnt_o,
  output logic [15:0]  rx_pkt_cnt_o,
  output logic         fmt_err_o,
  output logic         done_o
);

  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_END  = 2'b11;

  localparam logic [15:0] DLY_LOAD = 16'(START_DELAY);
  localparam logic [15:0] GAP_LOAD = 16'(IPG > 0 ? IPG - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    SEND,
    GAP,
    DONE
  } state_t;

  logic [133:0] memory [MEM_DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           cnt;
  logic [133:0]          beat;
  logic [1:0]            tag;
  logic                  last_addr;

  assign beat      = memory[addr];
  assign tag       = beat[133:132];
  assign last_addr = (addr == ADDR_WIDTH'(MEM_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      cnt           <= '0;
      data_in       <= '0;
      data_in_valid <= 1'b0;
      tx_pkt_cnt_o  <= '0;
      done_o        <= 1'b0;
    end else begin
      data_in_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gen_en_i) begin
            state <= WAIT_START;
            cnt   <= DLY_LOAD;
          end
        end
        WAIT_START: begin
          if (!gen_en_i) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= SEND;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SEND: begin
          if (tag == TAG_END) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            data_in       <= beat;
            data_in_valid <= 1'b1;
            addr          <= addr + 1'b1;
            if (tag == TAG_TAIL && tx_pkt_cnt_o != 16'hFFFF) begin
              tx_pkt_cnt_o <= tx_pkt_cnt_o + 16'd1;
            end
            // Enable is only honoured at packet boundaries.
            if (last_addr) begin
              state <= DONE;
            end else if (tag == TAG_TAIL) begin
              if (IPG > 0) begin
                state <= GAP;
                cnt   <= GAP_LOAD;
              end else if (!gen_en_i) begin
                state <= IDLE;
              end
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= gen_en_i ? SEND : IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DONE: begin
          done_o <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic       in_pkt;
  logic [1:0] rx_tag;
  logic       unused_rx_bits;

  assign rx_tag         = data_out[133:132];
  assign unused_rx_bits = ^data_out[131:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt       <= 1'b0;
      rx_pkt_cnt_o <= '0;
      fmt_err_o    <= 1'b0;
    end else if (data_out_valid) begin
      unique case (rx_tag)
        TAG_HEAD: begin
          if (in_pkt) fmt_err_o <= 1'b1;
          in_pkt <= 1'b1;
        end
        TAG_BODY: begin
          if (!in_pkt) fmt_err_o <= 1'b1;
        end
        TAG_TAIL: begin
          if (!in_pkt) begin
            fmt_err_o <= 1'b1;
          end else begin
            in_pkt <= 1'b0;
            if (rx_pkt_cnt_o != 16'hFFFF) begin
              rx_pkt_cnt_o <= rx_pkt_cnt_o + 16'd1;
            end
          end
        end
        default: begin
          fmt_err_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_pkt_gen.sv
// Self-checking bench: randomized packet streams compared
// against a timeline model derived from the packet rules.
module tb_fast_pkt_gen;

  localparam int MD = 32;
  localparam int AW = 5;
  localparam int SD = 4;
  localparam int GA = 8;
  localparam int GB = 0;

  typedef struct packed {
    int           t;
    logic [15:0]  c;
    logic [133:0] d;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_a, en_a, vld_a, dov_a, err_a, done_a_o;
  logic [133:0] din_a, dout_a;
  logic [15:0]  tx_a, rx_a;
  logic         rst_b, en_b, vld_b, err_b, done_b_o;
  logic [133:0] din_b;
  logic [15:0]  tx_b, rx_b;

  always #5 clk = ~clk;

  fast_pkt_gen #(
    .MEM_DEPTH(MD), .ADDR_WIDTH(AW), .START_DELAY(SD), .IPG(GA)
  ) dut_a (
    .clk(clk), .reset(rst_a), .gen_en_i(en_a),
    .data_in_valid(vld_a), .data_in(din_a),
    .data_out_valid(dov_a), .data_out(dout_a),
    .tx_pkt_cnt_o(tx_a), .rx_pkt_cnt_o(rx_a),
    .fmt_err_o(err_a), .done_o(done_a_o)
  );

  fast_pkt_gen #(
    .MEM_DEPTH(MD), .ADDR_WIDTH(AW), .START_DELAY(SD), .IPG(GB)
  ) dut_b (
    .clk(clk), .reset(rst_b), .gen_en_i(en_b),
    .data_in_valid(vld_b), .data_in(din_b),
    .data_out_valid(1'b0), .data_out('0),
    .tx_pkt_cnt_o(tx_b), .rx_pkt_cnt_o(rx_b),
    .fmt_err_o(err_b), .done_o(done_b_o)
  );

  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           done_a = -1;
  int           done_b = -1;
  ev_t          log_a[$];
  ev_t          log_b[$];
  ev_t          exp_q[$];
  logic [133:0] mem_a [MD];
  logic [133:0] mem_b [MD];
  logic [133:0] tmpm [MD];
  int           m_rx = 0;
  bit           m_in = 0;
  bit           m_err = 0;

  function automatic logic [133:0] mk(input logic [1:0] tg);
    logic [3:0] inv;
    inv = (tg == 2'b10) ? 4'($urandom_range(0, 15)) : 4'h0;
    return {tg, inv, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [133:0] obs,
                     input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (vld_a) log_a.push_back('{cyc, tx_a, din_a});
    if (vld_b) log_b.push_back('{cyc, tx_b, din_b});
    if (done_a_o && done_a < 0) done_a = cyc;
    if (done_b_o && done_b < 0) done_b = cyc;
  endtask

  task automatic gen(input int npk, input bit marker);
    int idx;
    int len;
    idx = 0;
    for (int p = 0; p < npk && idx < MD; p++) begin
      len = $urandom_range(2, 5);
      for (int k = 0; k < len && idx < MD; k++) begin
        tmpm[idx] = mk(k == 0 ? 2'b01 : (k == len - 1 ? 2'b10 : 2'b00));
        idx++;
      end
    end
    if (marker) for (int i = idx; i < MD; i++) tmpm[i] = mk(2'b11);
  endtask

  task automatic load(input bit sel);
    for (int i = 0; i < MD; i++) begin
      if (sel) begin
        mem_b[i] = tmpm[i];
        dut_b.memory[i] = tmpm[i];
      end else begin
        mem_a[i] = tmpm[i];
        dut_a.memory[i] = tmpm[i];
      end
    end
  endtask

  task automatic hold(input bit sel);
    if (sel) begin rst_b = 1'b1; en_b = 1'b1; end
    else begin rst_a = 1'b1; en_a = 1'b1; end
    repeat (4) tick();
  endtask

  task automatic release_rst(input bit sel, output int n);
    if (sel) begin rst_b = 1'b0; log_b.delete(); done_b = -1; end
    else begin rst_a = 1'b0; log_a.delete(); done_a = -1; end
    n = cyc + 1;
  endtask

  // Beat timeline from the rules: first beat S+2 after enable,
  // consecutive beats within a packet, G idle cycles after a tail.
  task automatic model(input bit sel, input int n, input int g,
                       output int done_t, output int tails);
    logic [133:0] e;
    int t;
    exp_q.delete();
    t = n + SD + 2;
    tails = 0;
    done_t = -1;
    for (int a = 0; a < MD; a++) begin
      e = sel ? mem_b[a] : mem_a[a];
      if (e[133:132] == 2'b11) begin
        done_t = t;
        break;
      end
      if (e[133:132] == 2'b10) tails++;
      exp_q.push_back('{t, 16'(tails), e});
      if (a == MD - 1) begin
        done_t = t + 1;
        break;
      end
      t += (e[133:132] == 2'b10) ? g + 1 : 1;
    end
  endtask

  task automatic run(input bit sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel ? done_b : done_a) >= 0) break;
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic cmp(input bit sel, input string nm,
                     input int exp_done, input int tails);
    ev_t act[$];
    int  n;
    act = sel ? log_b : log_a;
    chk({nm, ".beats"}, act.size(), exp_q.size());
    n = (act.size() < exp_q.size()) ? act.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.t%0d", nm, i), act[i].t, exp_q[i].t);
      chk($sformatf("%s.cnt%0d", nm, i), act[i].c, exp_q[i].c);
      chk($sformatf("%s.d%0d", nm, i), act[i].d, exp_q[i].d);
    end
    chk({nm, ".done_t"}, sel ? done_b : done_a, exp_done);
    chk({nm, ".tx"}, sel ? tx_b : tx_a, 16'(tails));
    chk({nm, ".done_hold"}, sel ? done_b_o : done_a_o, 1'b1);
    chk({nm, ".vld_off"}, sel ? vld_b : vld_a, 1'b0);
  endtask

  task automatic rx_beat(input logic [1:0] tg, input bit v);
    dout_a = mk(tg);
    dov_a = v;
    tick();
    dov_a = 1'b0;
    if (v) begin
      case (tg)
        2'b01: begin if (m_in) m_err = 1; m_in = 1; end
        2'b00: if (!m_in) m_err = 1;
        2'b10: begin
          if (!m_in) m_err = 1;
          else begin m_rx++; m_in = 0; end
        end
        default: m_err = 1;
      endcase
    end
    chk($sformatf("rx.cnt.%0d", cyc), rx_a, 16'(m_rx));
    chk($sformatf("rx.err.%0d", cyc), err_a, m_err);
  endtask

  initial begin
    int n, n2, t0, dt, tl;
    rst_a = 1'b0; en_a = 1'b0; dov_a = 1'b0; dout_a = '0;
    rst_b = 1'b0; en_b = 1'b0;

    gen(4, 1'b1);
    load(1'b0);
    tmpm[0] = mk(2'b01);
    tmpm[1] = mk(2'b00);
    tmpm[2] = mk(2'b00);
    tmpm[3] = mk(2'b10);
    for (int i = 4; i < MD; i++) tmpm[i] = mk(2'b11);
    load(1'b1);

    hold(1'b0);
    chk("rst.valid", vld_a, 1'b0);
    chk("rst.data", din_a, '0);
    chk("rst.tx", tx_a, 16'h0);
    chk("rst.rx", rx_a, 16'h0);
    chk("rst.err", err_a, 1'b0);
    chk("rst.done", done_a_o, 1'b0);
    release_rst(1'b0, n);
    model(1'b0, n, GA, dt, tl);
    run(1'b0, 300);
    cmp(1'b0, "a1", dt, tl);

    hold(1'b1);
    release_rst(1'b1, n);
    model(1'b1, n, GB, dt, tl);
    run(1'b1, 100);
    cmp(1'b1, "b1", dt, tl);

    rx_beat(2'b01, 1'b1);
    rx_beat(2'b00, 1'b1);
    rx_beat(2'b10, 1'b1);
    rx_beat(2'b00, 1'b1);
    rx_beat(2'b01, 1'b1);
    rx_beat(2'b10, 1'b1);
    rx_beat(2'b11, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rx_beat(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    tmpm[0] = mk(2'b01);
    for (int i = 1; i < 4; i++) tmpm[i] = mk(2'b00);
    tmpm[4] = mk(2'b10);
    tmpm[5] = mk(2'b01);
    tmpm[6] = mk(2'b10);
    for (int i = 7; i < MD; i++) tmpm[i] = mk(2'b11);
    load(1'b0);
    hold(1'b0);
    chk("a3.rx_clr", rx_a, 16'h0);
    chk("a3.err_clr", err_a, 1'b0);
    release_rst(1'b0, n);
    t0 = n + SD + 2;
    for (int i = 0; i < 100; i++) begin
      if (log_a.size() > 0 && log_a[$].d[133:132] == 2'b00) break;
      tick();
    end
    en_a = 1'b0;
    repeat (25) tick();
    chk("a3.beats_paused", log_a.size(), 5);
    chk("a3.tx_paused", tx_a, 16'd1);
    chk("a3.vld_paused", vld_a, 1'b0);
    en_a = 1'b1;
    n2 = cyc + 1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{t0 + i, (i == 4) ? 16'd1 : 16'd0, mem_a[i]});
    end
    exp_q.push_back('{n2 + SD + 2, 16'd1, mem_a[5]});
    exp_q.push_back('{n2 + SD + 3, 16'd2, mem_a[6]});
    run(1'b0, 200);
    cmp(1'b0, "a3", n2 + SD + 3 + GA + 1, 2);

    hold(1'b0);
    release_rst(1'b0, n);
    for (int i = 0; i < 100; i++) begin
      if (log_a.size() >= 2) break;
      tick();
    end
    rst_a = 1'b1;
    tick();
    chk("a4.vld_rst", vld_a, 1'b0);
    chk("a4.tx_rst", tx_a, 16'h0);
    release_rst(1'b0, n);
    model(1'b0, n, GA, dt, tl);
    run(1'b0, 300);
    cmp(1'b0, "a4", dt, tl);

    gen(1000, 1'b0);
    load(1'b1);
    hold(1'b1);
    release_rst(1'b1, n);
    model(1'b1, n, GB, dt, tl);
    run(1'b1, 200);
    cmp(1'b1, "b2", dt, tl);
    chk("b.rx_idle", rx_b, 16'h0);
    chk("b.err_idle", err_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
